// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_seq
//  Purpose  : Registered EX-stage ALU control unit. Decodes alu_op/fn into an
//             ALU operation code, sequences multi-cycle MULT/DIV operations
//             with a busy counter, and drives the pipeline stall, the mult/div
//             start pulse and the HI/LO write enable.
//  Ports    : clk         in   clock, rising edge
//             rst_n       in   asynchronous active-low reset
//             valid_in    in   alu_op/fn valid this cycle
//             alu_op      in   [1:0] main-decoder op class
//             fn          in   [5:0] instruction funct field
//             flush       in   synchronous pipeline flush / abort
//             alu_control out  [ALU_CTRL_W-1:0] registered ALU operation code
//             valid_out   out  1-cycle pulse per accepted op
//             md_start    out  1-cycle pulse starting the mult/div unit
//             stall       out  high while a mult/div op occupies the unit
//             hilo_we     out  1-cycle HI/LO write enable at md completion
//             illegal     out  unsupported funct with alu_op=10 (with valid_out)
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_seq #(
  parameter int ALU_CTRL_W = 4,
  parameter int MD_LATENCY = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [1:0]            alu_op,
  input  logic [5:0]            fn,
  input  logic                  flush,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  valid_out,
  output logic                  md_start,
  output logic                  stall,
  output logic                  hilo_we,
  output logic                  illegal
);

  localparam logic [3:0] c_and   = 4'd0;
  localparam logic [3:0] c_or    = 4'd1;
  localparam logic [3:0] c_add   = 4'd2;
  localparam logic [3:0] c_sub   = 4'd3;
  localparam logic [3:0] c_slt   = 4'd4;
  localparam logic [3:0] c_nor   = 4'd5;
  localparam logic [3:0] c_xor   = 4'd6;
  localparam logic [3:0] c_sll   = 4'd7;
  localparam logic [3:0] c_srl   = 4'd8;
  localparam logic [3:0] c_sra   = 4'd9;
  localparam logic [3:0] c_mult  = 4'd10;
  localparam logic [3:0] c_multu = 4'd11;
  localparam logic [3:0] c_div   = 4'd12;
  localparam logic [3:0] c_divu  = 4'd13;

  // Counter is loaded with MD_LATENCY-1 so that it reaches zero in the last
  // busy cycle; 8 bits cover the full legal latency range.
  localparam logic [7:0] c_md_init = 8'(MD_LATENCY - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  logic [ALU_CTRL_W-1:0] r_ctrl;
  logic [ALU_CTRL_W-1:0] w_ctrl_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_md_start;
  logic                  w_md_start_nxt;
  logic                  r_stall;
  logic                  w_stall_nxt;
  logic                  r_hilo_we;
  logic                  w_hilo_we_nxt;
  logic                  r_illegal;
  logic                  w_illegal_nxt;

  logic [3:0]            w_code;
  logic                  w_is_md;
  logic                  w_bad_fn;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_code   = c_add;
    w_is_md  = 1'b0;
    w_bad_fn = 1'b0;
    unique case (alu_op)
      2'b00: w_code = c_add;
      2'b01: w_code = c_sub;
      2'b11: w_code = c_or;
      2'b10: begin
        case (fn)
          6'h20, 6'h21: w_code = c_add;
          6'h22, 6'h23: w_code = c_sub;
          6'h24:        w_code = c_and;
          6'h25:        w_code = c_or;
          6'h26:        w_code = c_xor;
          6'h27:        w_code = c_nor;
          6'h2A:        w_code = c_slt;
          6'h00:        w_code = c_sll;
          6'h02:        w_code = c_srl;
          6'h03:        w_code = c_sra;
          6'h18: begin w_code = c_mult;  w_is_md = 1'b1; end
          6'h19: begin w_code = c_multu; w_is_md = 1'b1; end
          6'h1A: begin w_code = c_div;   w_is_md = 1'b1; end
          6'h1B: begin w_code = c_divu;  w_is_md = 1'b1; end
          default: begin
            w_code   = c_add;
            w_bad_fn = 1'b1;
          end
        endcase
      end
      default: w_code = c_add;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. All outputs are registered, so each
  // value computed here is what the block presents in the following cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ctrl_nxt     = r_ctrl;
    w_valid_nxt    = 1'b0;
    w_md_start_nxt = 1'b0;
    w_stall_nxt    = 1'b0;
    w_hilo_we_nxt  = 1'b0;
    w_illegal_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (valid_in && !flush) begin
          w_ctrl_nxt    = ALU_CTRL_W'(w_code);
          w_valid_nxt   = 1'b1;
          w_illegal_nxt = w_bad_fn;
          if (w_is_md) begin
            w_state_nxt    = ST_RUN;
            w_cnt_nxt      = c_md_init;
            w_md_start_nxt = 1'b1;
            w_stall_nxt    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // valid_in is ignored here: upstream is stalled and holds its inputs.
        if (flush) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
          w_stall_nxt = 1'b1;
          // hilo_we is registered, so it is raised one cycle ahead: it shows
          // up in the cycle where the counter reads zero.
          w_hilo_we_nxt = (r_cnt == 8'd1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_md_start <= 1'b0;
      r_stall    <= 1'b0;
      r_hilo_we  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_valid    <= w_valid_nxt;
      r_md_start <= w_md_start_nxt;
      r_stall    <= w_stall_nxt;
      r_hilo_we  <= w_hilo_we_nxt;
      r_illegal  <= w_illegal_nxt;
    end
  end

  assign alu_control = r_ctrl;
  assign valid_out   = r_valid;
  assign md_start    = r_md_start;
  assign stall       = r_stall;
  assign hilo_we     = r_hilo_we;
  assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_seq
//  Purpose  : Self-checking bench for alu_ctrl_seq. Directed scenarios plus a
//             randomized phase, all compared against a schedule-based
//             reference model (decode table + md-op completion cycle).
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;

  localparam int W = 4;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   fn = 6'd0;
  logic         flush = 1'b0;
  logic [W-1:0] alu_control;
  logic         valid_out;
  logic         md_start;
  logic         stall;
  logic         hilo_we;
  logic         illegal;

  alu_ctrl_seq #(.ALU_CTRL_W(W), .MD_LATENCY(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .alu_op      (alu_op),
    .fn          (fn),
    .flush       (flush),
    .alu_control (alu_control),
    .valid_out   (valid_out),
    .md_start    (md_start),
    .stall       (stall),
    .hilo_we     (hilo_we),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model: funct lookup table and md-op schedule.
  int lut [64];
  int legal_fn [14] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                        'h2A, 'h00, 'h02, 'h03, 'h18, 'h19};
  int cyc;          // index of the cycle whose inputs are currently applied
  bit m_busy;       // an md op occupies the unit
  int m_end;        // cycle in which the md op completes (hilo_we cycle)
  int e_ctrl;
  bit e_valid, e_md, e_stall, e_hilo, e_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_end = -1; e_ctrl = 0;
    e_valid = 0; e_md = 0; e_stall = 0; e_hilo = 0; e_ill = 0;
    cyc = 0;
  endtask

  // Predict the outputs of cycle cyc+1 from the inputs of cycle cyc.
  task automatic model_step();
    e_valid = 0; e_md = 0; e_stall = 0; e_hilo = 0; e_ill = 0;
    if (m_busy) begin
      if (flush || cyc >= m_end) begin
        m_busy = 0;
      end else begin
        e_stall = 1;
        e_hilo  = (cyc + 1 == m_end);
      end
    end else if (valid_in && !flush) begin
      e_valid = 1;
      case (alu_op)
        2'b00: e_ctrl = 2;
        2'b01: e_ctrl = 3;
        2'b11: e_ctrl = 1;
        default: begin
          if (lut[fn] < 0) begin
            e_ctrl = 2;
            e_ill  = 1;
          end else begin
            e_ctrl = lut[fn];
          end
        end
      endcase
      if (alu_op == 2'b10 && e_ctrl >= 10) begin
        m_busy  = 1;
        m_end   = cyc + L;
        e_md    = 1;
        e_stall = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("alu_control", 32'(alu_control), 32'(e_ctrl));
    chk("valid_out",   32'(valid_out),   32'(e_valid));
    chk("md_start",    32'(md_start),    32'(e_md));
    chk("stall",       32'(stall),       32'(e_stall));
    chk("hilo_we",     32'(hilo_we),     32'(e_hilo));
    chk("illegal",     32'(illegal),     32'(e_ill));
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [5:0] f, input bit fl);
    valid_in = v; alu_op = op; fn = f; flush = fl;
    @(posedge clk);
    #1;
    model_step();
    cyc++;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) lut[i] = -1;
    lut['h20] = 2; lut['h21] = 2; lut['h22] = 3; lut['h23] = 3;
    lut['h24] = 0; lut['h25] = 1; lut['h26] = 6; lut['h27] = 5;
    lut['h2A] = 4; lut['h00] = 7; lut['h02] = 8; lut['h03] = 9;
    lut['h18] = 10; lut['h19] = 11; lut['h1A] = 12; lut['h1B] = 13;
    model_reset();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Decode sweep
    step(1, 2'b10, 6'h2A, 0);
    chk("t2_slt", 32'(alu_control), 32'd4);
    step(1, 2'b01, 6'h00, 0);
    step(1, 2'b11, 6'h00, 0);
    step(0, 2'b00, 6'h00, 0);

    // Illegal funct
    step(1, 2'b10, 6'h3F, 0);
    chk("t3_illegal", 32'(illegal), 32'd1);
    step(0, 2'b00, 6'h00, 0);

    // MULT with upstream holding an ADD behind it
    step(1, 2'b10, 6'h18, 0);
    chk("t4_md_start", 32'(md_start), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 2'b00, 6'h00, 0);
    chk("t4_stall_low", 32'(stall), 32'd0);
    step(1, 2'b00, 6'h00, 0);
    chk("t4_add_valid", 32'(valid_out), 32'd1);
    step(0, 2'b00, 6'h00, 0);

    // DIV flushed mid-run
    step(1, 2'b10, 6'h1A, 0);
    step(0, 2'b00, 6'h00, 0);
    step(0, 2'b00, 6'h00, 1);
    chk("t5_stall_flush", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 2'b00, 6'h00, 0);

    // Flush in IDLE drops the op
    step(1, 2'b10, 6'h19, 1);

    // Back-to-back single-cycle ops
    step(1, 2'b10, 6'h20, 0);
    step(1, 2'b10, 6'h22, 0);
    step(1, 2'b10, 6'h24, 0);
    chk("t6_and", 32'(alu_control), 32'd0);
    step(0, 2'b00, 6'h00, 0);

    // Asynchronous reset in the middle of an md op
    step(1, 2'b10, 6'h1B, 0);
    step(0, 2'b00, 6'h00, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 2'b00, 6'h00, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [5:0] rf;
      if ($urandom_range(0, 3) != 0) rf = 6'(legal_fn[$urandom_range(0, 13)]);
      else if ($urandom_range(0, 1) != 0) rf = 6'h1A + 6'($urandom_range(0, 1));
      else rf = 6'($urandom_range(0, 63));
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rf,
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
